// File: rtl/ascon_seq_pkg.sv
// Shared types and constants for the Ascon batch sequencer.
// Holds the FSM state encoding, the status byte layout and the default parameter values.
package ascon_seq_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int RUNS_WIDTH_DEF = 8;
  localparam int GAP_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_TAG,
    S_DRAIN,
    S_GAP,
    S_DONE
  } seq_state_e;

  // Bit positions inside the status byte exposed as REG_CRYPT_STATUS.
  localparam int ST_BUSY     = 0;
  localparam int ST_STARTED  = 1;
  localparam int ST_CT_SEEN  = 2;
  localparam int ST_TAG_SEEN = 3;
  localparam int ST_DONE     = 4;
  localparam int ST_OVERFLOW = 5;

endpackage

// File: rtl/ascon_result_holdbuf.sv
// Two-slot (ciphertext, tag) holding buffer that drains into the result FIFO, CT first.
// A strobe hitting an occupied slot is dropped and raises a sticky overflow flag.
module ascon_result_holdbuf
  import ascon_seq_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   clear_overflow,
  input  logic                   capture_en,
  input  logic                   ct_valid,
  input  logic [pDATA_WIDTH-1:0] ct,
  input  logic                   tag_valid,
  input  logic [pDATA_WIDTH-1:0] tag,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [pDATA_WIDTH-1:0] fifo_wr_data,
  output logic                   empty_next,
  output logic                   overflow
);

  logic                   ct_full_q, tag_full_q;
  logic [pDATA_WIDTH-1:0] ct_q, tag_q;
  logic                   ct_take, tag_take, ct_pop, tag_pop;

  // NOTE: every signal gets a value before any branch so no latch can be inferred.
  always_comb begin
    fifo_wr_en   = (ct_full_q | tag_full_q) & ~fifo_full;
    fifo_wr_data = ct_full_q ? ct_q : tag_q;
    ct_pop       = fifo_wr_en & ct_full_q;
    tag_pop      = fifo_wr_en & ~ct_full_q;
    ct_take      = capture_en & ct_valid & ~ct_full_q;
    tag_take     = capture_en & tag_valid & ~tag_full_q;
    // Lets the sequencer leave DRAIN on the same cycle the last word goes out.
    empty_next   = ~((ct_full_q & ~ct_pop) | (tag_full_q & ~tag_pop));
  end

  // NOTE: sequential state uses non-blocking assignments only; the data slots are
  // reset as well so fifo_wr_data reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ct_full_q  <= 1'b0;
      tag_full_q <= 1'b0;
      ct_q       <= '0;
      tag_q      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (clear_overflow) begin
        overflow <= 1'b0;
      end else if (capture_en & ((ct_valid & ct_full_q) | (tag_valid & tag_full_q))) begin
        overflow <= 1'b1;
      end

      if (flush) begin
        ct_full_q  <= 1'b0;
        tag_full_q <= 1'b0;
      end else begin
        if (ct_take) begin
          ct_full_q <= 1'b1;
          ct_q      <= ct;
        end else if (ct_pop) begin
          ct_full_q <= 1'b0;
        end
        if (tag_take) begin
          tag_full_q <= 1'b1;
          tag_q      <= tag;
        end else if (tag_pop) begin
          tag_full_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ascon_batch_sequencer.sv
// Runs the Ascon core through a batch of back-to-back encryptions, advancing the nonce,
// buffering CT/tag into the result FIFO and producing the scope trigger and status byte.
module ascon_batch_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
  parameter int pRUNS_WIDTH = RUNS_WIDTH_DEF,
  parameter int pGAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_go,
  input  logic                   cfg_abort,
  input  logic [pRUNS_WIDTH-1:0] cfg_num_runs,
  input  logic                   cfg_nonce_inc,
  input  logic [pDATA_WIDTH-1:0] cfg_nonce,
  output logic                   core_start,
  output logic [pDATA_WIDTH-1:0] core_nonce,
  input  logic                   core_busy,
  input  logic                   core_ct_valid,
  input  logic [pDATA_WIDTH-1:0] core_ct,
  input  logic                   core_tag_valid,
  input  logic [pDATA_WIDTH-1:0] core_tag,
  output logic                   fifo_wr_en,
  output logic [pDATA_WIDTH-1:0] fifo_wr_data,
  input  logic                   fifo_full,
  output logic [pRUNS_WIDTH-1:0] run_idx,
  output logic                   trigger,
  output logic [7:0]             status
);

  localparam int GW = (pGAP_CYCLES > 1) ? $clog2(pGAP_CYCLES) : 1;

  seq_state_e             state_q, state_d;
  logic [pRUNS_WIDTH-1:0] run_idx_q, num_runs_q;
  logic [pDATA_WIDTH-1:0] base_q;
  logic                   inc_q;
  logic [GW-1:0]          gap_cnt_q;
  logic                   started_q, ct_seen_q, tag_seen_q;
  logic                   go_ok, last_run, drained, empty_next, overflow;

  assign go_ok    = cfg_go & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign last_run = (run_idx_q + pRUNS_WIDTH'(1)) == num_runs_q;
  assign drained  = empty_next & ~core_busy;

  ascon_result_holdbuf #(.pDATA_WIDTH(pDATA_WIDTH)) u_holdbuf (
    .clk            (clk),
    .reset          (reset),
    .flush          (cfg_abort),
    .clear_overflow (go_ok),
    .capture_en     (state_q == S_WAIT_TAG),
    .ct_valid       (core_ct_valid),
    .ct             (core_ct),
    .tag_valid      (core_tag_valid),
    .tag            (core_tag),
    .fifo_full      (fifo_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .empty_next     (empty_next),
    .overflow       (overflow)
  );

  always_comb begin
    state_d = state_q;
    if (cfg_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (cfg_go) state_d = (cfg_num_runs == '0) ? S_DONE : S_LAUNCH;
        S_LAUNCH:       state_d = S_WAIT_TAG;
        S_WAIT_TAG:     if (core_tag_valid) state_d = S_DRAIN;
        S_DRAIN: begin
          if (drained) begin
            if (last_run)              state_d = S_DONE;
            else if (pGAP_CYCLES == 0) state_d = S_LAUNCH;
            else                       state_d = S_GAP;
          end
        end
        S_GAP:   if (gap_cnt_q == GW'(pGAP_CYCLES - 1)) state_d = S_LAUNCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_idx_q  <= '0;
      num_runs_q <= '0;
      base_q     <= '0;
      inc_q      <= 1'b0;
      gap_cnt_q  <= '0;
      started_q  <= 1'b0;
      ct_seen_q  <= 1'b0;
      tag_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (go_ok) begin
        base_q     <= cfg_nonce;
        num_runs_q <= cfg_num_runs;
        inc_q      <= cfg_nonce_inc;
        run_idx_q  <= '0;
        started_q  <= 1'b0;
        ct_seen_q  <= 1'b0;
        tag_seen_q <= 1'b0;
      end

      if ((state_q == S_DRAIN) && drained && !last_run) run_idx_q <= run_idx_q + pRUNS_WIDTH'(1);

      if (state_q == S_GAP) gap_cnt_q <= gap_cnt_q + GW'(1);
      else                  gap_cnt_q <= '0;

      // core_started stays high while a run is in flight; the seen flags persist to the next launch.
      if (state_q == S_LAUNCH) begin
        started_q  <= 1'b1;
        ct_seen_q  <= 1'b0;
        tag_seen_q <= 1'b0;
      end else if (state_q == S_WAIT_TAG) begin
        if (core_ct_valid) ct_seen_q <= 1'b1;
        if (core_tag_valid) begin
          tag_seen_q <= 1'b1;
          started_q  <= 1'b0;
        end
      end
    end
  end

  assign core_start = (state_q == S_LAUNCH);
  assign trigger    = (state_q == S_LAUNCH) | (state_q == S_WAIT_TAG);
  assign run_idx    = run_idx_q;
  assign core_nonce = inc_q ? base_q + pDATA_WIDTH'(run_idx_q) : base_q;

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = (state_q != S_IDLE) & (state_q != S_DONE);
    status[ST_STARTED]  = started_q;
    status[ST_CT_SEEN]  = ct_seen_q;
    status[ST_TAG_SEEN] = tag_seen_q;
    status[ST_DONE]     = (state_q == S_DONE);
    status[ST_OVERFLOW] = overflow;
  end

endmodule

// File: tb/tb_ascon_batch_sequencer.sv
// Scoreboard bench for ascon_batch_sequencer: stimulus pushes expected nonces and FIFO
// words into queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_ascon_batch_sequencer;

  localparam int W = 128;
  localparam int R = 8;
  localparam int G = 16;

  logic         clk = 1'b0;
  logic         reset, cfg_go, cfg_abort, cfg_nonce_inc;
  logic [R-1:0] cfg_num_runs;
  logic [W-1:0] cfg_nonce;
  logic         core_start, core_busy, core_ct_valid, core_tag_valid;
  logic [W-1:0] core_nonce, core_ct, core_tag, fifo_wr_data;
  logic         fifo_wr_en, fifo_full, trigger;
  logic [R-1:0] run_idx;
  logic [7:0]   status;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_starts = 0;
  int n_writes = 0;
  logic [W-1:0] nonce_q[$];
  logic [W-1:0] word_q[$];

  ascon_batch_sequencer #(.pDATA_WIDTH(W), .pRUNS_WIDTH(R), .pGAP_CYCLES(G)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_go         (cfg_go),
    .cfg_abort      (cfg_abort),
    .cfg_num_runs   (cfg_num_runs),
    .cfg_nonce_inc  (cfg_nonce_inc),
    .cfg_nonce      (cfg_nonce),
    .core_start     (core_start),
    .core_nonce     (core_nonce),
    .core_busy      (core_busy),
    .core_ct_valid  (core_ct_valid),
    .core_ct        (core_ct),
    .core_tag_valid (core_tag_valid),
    .core_tag       (core_tag),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_full      (fifo_full),
    .run_idx        (run_idx),
    .trigger        (trigger),
    .status         (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [15:0] id, input int i);
    return {id, 80'h0, 32'(i)};
  endfunction

  // Monitor: nonce on every launch, FIFO word on every write.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_start) begin
        n_starts++;
        check("trigger_at_start", W'(trigger), W'(1));
        if (nonce_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got nonce %h want no launch", core_nonce);
        end else begin
          check("core_nonce", core_nonce, nonce_q.pop_front());
        end
      end
      if (fifo_wr_en) begin
        n_writes++;
        check("wr_while_full", W'(fifo_full), W'(0));
        if (word_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got %h want no write", fifo_wr_data);
        end else begin
          check("fifo_word", fifo_wr_data, word_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_go(input logic [R-1:0] n, input logic inc, input logic [W-1:0] base,
                          output int g);
    cfg_go = 1'b1; cfg_num_runs = n; cfg_nonce_inc = inc; cfg_nonce = base;
    g = cyc;
    tick();
    cfg_go = 1'b0;
  endtask

  task automatic wait_start(input string name, output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      if (core_start) begin
        c = cyc;
        return;
      end
      tick();
    end
    total++; bad++;
    $display("FAIL %s: got no core_start want one within 200 cycles", name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      if (status[4]) return;
      tick();
    end
    total++; bad++;
    $display("FAIL %s: got done=0 want done=1 within 200 cycles", name);
  endtask

  // Called on the LAUNCH cycle; returns one cycle after the tag strobe.
  task automatic run_core(input logic [W-1:0] ct, input logic [W-1:0] tag, output int t_tag);
    tick(); core_busy = 1'b1;
    tick(); core_ct_valid = 1'b1; core_ct = ct; word_q.push_back(ct);
    tick(); core_ct_valid = 1'b0; core_tag_valid = 1'b1; core_tag = tag; word_q.push_back(tag);
    t_tag = cyc;
    check("trigger_in_run", W'(trigger), W'(1));
    tick(); core_tag_valid = 1'b0; core_busy = 1'b0;
    check("trigger_after_tag", W'(trigger), W'(0));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_status"}, W'(status), W'(0));
    check({name, "_core_start"}, W'(core_start), W'(0));
    check({name, "_trigger"}, W'(trigger), W'(0));
    check({name, "_run_idx"}, W'(run_idx), W'(0));
    check({name, "_core_nonce"}, core_nonce, W'(0));
    check({name, "_fifo_wr_en"}, W'(fifo_wr_en), W'(0));
    check({name, "_fifo_wr_data"}, fifo_wr_data, W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, c, t, r, w0;
    logic [W-1:0] base;
    reset = 1'b1; cfg_go = 1'b0; cfg_abort = 1'b0; cfg_nonce_inc = 1'b0;
    cfg_num_runs = '0; cfg_nonce = '0; core_busy = 1'b0; core_ct_valid = 1'b0;
    core_tag_valid = 1'b0; core_ct = '0; core_tag = '0; fifo_full = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_quiet("reset");

    // Three incrementing runs, gap spacing, done timing and final status.
    base = 128'h000102030405060708090a0b0c0d0e0f;
    nonce_q.push_back(base);
    nonce_q.push_back(128'h000102030405060708090a0b0c0d0e10);
    nonce_q.push_back(128'h000102030405060708090a0b0c0d0e11);
    w0 = n_writes;
    drive_go(8'd3, 1'b1, base, g);
    wait_start("t1_start0", c);
    check("t1_go_to_start", W'(c), W'(g + 1));
    run_core(mk(16'hC7A0, 0), mk(16'h7A60, 0), t);
    for (int i = 1; i < 3; i++) begin
      wait_start("t1_start", c);
      check("t1_spacing", W'(c - t), W'(2 + G));
      run_core(mk(16'hC7A0, i), mk(16'h7A60, i), t);
    end
    check("t1_done_not_yet", W'(status[4]), W'(0));
    tick();
    check("t1_status_done", W'(status), W'(8'h1C));
    check("t1_run_idx", W'(run_idx), W'(2));
    check("t1_writes", W'(n_writes - w0), W'(6));

    // Zero runs: done the cycle after go, no launch.
    drive_go(8'd0, 1'b1, 128'h55, g);
    check("t2_done", W'(status[4]), W'(1));
    check("t2_busy", W'(status[0]), W'(0));
    check("t2_no_start", W'(core_start), W'(0));
    tick();
    check("t2_no_start_later", W'(core_start), W'(0));

    // All-ones base wraps to zero on the second run.
    nonce_q.push_back({W{1'b1}});
    nonce_q.push_back('0);
    drive_go(8'd2, 1'b1, {W{1'b1}}, g);
    for (int i = 0; i < 2; i++) begin
      wait_start("t3_start", c);
      run_core(mk(16'hC3C3, i), mk(16'h7333, i), t);
    end
    wait_done("t3_done");
    check("t3_run_idx", W'(run_idx), W'(1));

    // FIFO full for 20 cycles during run 1, fixed nonce: next launch waits for the drain.
    base = 128'hfeedface_00000000_00000000_12345678;
    nonce_q.push_back(base);
    nonce_q.push_back(base);
    drive_go(8'd2, 1'b0, base, g);
    wait_start("t4_start0", c);
    fifo_full = 1'b1;
    run_core(mk(16'hC444, 0), mk(16'h7444, 0), t);
    while (cyc < c + 20) tick();
    fifo_full = 1'b0;
    r = cyc;
    wait_start("t4_start1", c);
    check("t4_start_after_drain", W'(c), W'(r + 2 + G));
    run_core(mk(16'hC444, 1), mk(16'h7444, 1), t);
    wait_done("t4_done");
    check("t4_no_overflow", W'(status[5]), W'(0));

    // Second CT strobe into an occupied slot: overflow, first CT kept.
    base = 128'h0123;
    nonce_q.push_back(base);
    drive_go(8'd1, 1'b1, base, g);
    wait_start("t5_start", c);
    fifo_full = 1'b1;
    tick(); core_busy = 1'b1;
    tick(); core_ct_valid = 1'b1; core_ct = mk(16'hC555, 1); word_q.push_back(core_ct);
    tick(); core_ct = mk(16'hC555, 2);
    tick(); core_ct_valid = 1'b0;
    check("t5_overflow", W'(status[5]), W'(1));
    core_tag_valid = 1'b1; core_tag = mk(16'h7555, 1); word_q.push_back(core_tag);
    tick(); core_tag_valid = 1'b0; core_busy = 1'b0; fifo_full = 1'b0;
    wait_done("t5_done");
    check("t5_status", W'(status), W'(8'h3C));
    cfg_abort = 1'b1;
    tick(); cfg_abort = 1'b0;
    check("t5_abort_keeps_overflow", W'(status[5]), W'(1));
    check("t5_abort_done_low", W'(status[4]), W'(0));

    // Abort mid-WAIT_TAG: idle next cycle, later strobes are not captured.
    nonce_q.push_back(128'h77);
    drive_go(8'd2, 1'b1, 128'h77, g);
    check("t6_go_clears_overflow", W'(status[5]), W'(0));
    wait_start("t6_start", c);
    tick(); core_busy = 1'b1;
    tick(); cfg_abort = 1'b1;
    tick(); cfg_abort = 1'b0; core_busy = 1'b0;
    check("t6_busy", W'(status[0]), W'(0));
    check("t6_done", W'(status[4]), W'(0));
    check("t6_trigger", W'(trigger), W'(0));
    core_ct_valid = 1'b1; core_ct = mk(16'hDEAD, 0);
    tick(); core_ct_valid = 1'b0;
    repeat (3) tick();

    // Reset during GAP, then a fresh batch starts at run 0.
    base = 128'hab00;
    nonce_q.push_back(base);
    drive_go(8'd3, 1'b1, base, g);
    wait_start("t7_start", c);
    run_core(mk(16'hC777, 0), mk(16'h7777, 0), t);
    repeat (3) tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    check_quiet("t7_reset");
    base = 128'hcd00;
    nonce_q.push_back(base);
    drive_go(8'd1, 1'b1, base, g);
    wait_start("t7_restart", c);
    run_core(mk(16'hC778, 0), mk(16'h7778, 0), t);
    wait_done("t7_done");
    check("t7_run_idx", W'(run_idx), W'(0));

    repeat (3) tick();
    check("nonce_sb_empty", W'(nonce_q.size()), W'(0));
    check("word_sb_empty", W'(word_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
